// File: rtl/dtack_wait_state_generator.sv
// Registered 68k DTACK/BERR generator for NUM_CH decoded devices.
// Each device runs on a wait-state count or on its own DTACK, with a bus-error timeout.
module dtack_wait_state_generator #(
   parameter int NUM_CH  = 4,
   parameter int WS_W    = 4,
   parameter int TO_W    = 10,
   parameter int TIMEOUT = 1023
) (
   input  logic                     Clock,
   input  logic                     Reset_L,
   input  logic                     AS_L,
   input  logic [NUM_CH-1:0]        Select_H,
   input  logic [NUM_CH-1:0]        UseExt_H,
   input  logic [NUM_CH*WS_W-1:0]   WaitStates,
   input  logic [NUM_CH-1:0]        ExtDtack_L,
   input  logic                     ClearTimeout_H,
   output logic                     DtackOut_L,
   output logic                     BErr_L,
   output logic                     Timeout_H,
   output logic [3:0]               TimeoutChan
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_BERR
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CH_W-1:0]   r_chan;
   logic              r_ext;
   logic [WS_W-1:0]   r_wcnt;
   logic [TO_W-1:0]   r_tcnt;
   logic              r_dtack_l;
   logic              r_berr_l;
   logic              r_timeout;
   logic [3:0]        r_tchan;

   logic              w_hit;
   logic [CH_W-1:0]   w_idx;
   logic              w_ext_new;
   logic [WS_W-1:0]   w_ws_new;
   logic              w_start;
   logic              w_set_to;
   logic [WS_W-1:0]   w_wcnt_n;
   logic [TO_W-1:0]   w_tcnt_n;
   logic [TO_W-1:0]   w_tcnt_inc;

   // Scan downwards so the lowest selected channel is the last to write.
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (Select_H[i]) begin
            w_hit = 1'b1;
            w_idx = CH_W'(i);
         end
      end
   end

   assign w_ext_new  = w_hit & UseExt_H[w_idx];
   assign w_ws_new   = WaitStates[w_idx*WS_W +: WS_W];
   assign w_tcnt_inc = r_tcnt + 1'b1;

   always_comb begin
      w_next   = r_state;
      w_wcnt_n = r_wcnt;
      w_tcnt_n = r_tcnt;
      w_start  = 1'b0;
      w_set_to = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!AS_L) begin
               w_start = 1'b1;
               if (!w_hit) begin
                  w_next = S_ACK;
               end else if (!w_ext_new && w_ws_new == '0) begin
                  w_next = S_ACK;
               end else if (w_ext_new && !ExtDtack_L[w_idx]) begin
                  w_next = S_ACK;
               end else begin
                  w_next   = S_WAIT;
                  w_wcnt_n = w_ws_new;
                  w_tcnt_n = '0;
               end
            end
         end
         S_WAIT: begin
            // An aborted cycle outranks any dtack or timeout on the same edge.
            if (AS_L) begin
               w_next = S_IDLE;
            end else if (!r_ext) begin
               w_wcnt_n = r_wcnt - 1'b1;
               if (r_wcnt == WS_W'(1)) begin
                  w_next = S_ACK;
               end
            end else if (!ExtDtack_L[r_chan]) begin
               w_next = S_ACK;
            end else begin
               w_tcnt_n = w_tcnt_inc;
               if (w_tcnt_inc == TO_W'(TIMEOUT)) begin
                  w_next   = S_BERR;
                  w_set_to = 1'b1;
               end
            end
         end
         S_ACK, S_BERR: begin
            if (AS_L) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_L) begin
         r_state   <= S_IDLE;
         r_chan    <= '0;
         r_ext     <= 1'b0;
         r_wcnt    <= '0;
         r_tcnt    <= '0;
         r_dtack_l <= 1'b1;
         r_berr_l  <= 1'b1;
         r_timeout <= 1'b0;
         r_tchan   <= '0;
      end else begin
         r_state   <= w_next;
         r_wcnt    <= w_wcnt_n;
         r_tcnt    <= w_tcnt_n;
         r_dtack_l <= (w_next != S_ACK);
         r_berr_l  <= (w_next != S_BERR);
         if (w_start) begin
            r_chan <= w_idx;
            r_ext  <= w_ext_new;
         end
         if (w_set_to) begin
            r_timeout <= 1'b1;
            r_tchan   <= 4'(r_chan);
         end else if (ClearTimeout_H) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign DtackOut_L  = r_dtack_l;
   assign BErr_L      = r_berr_l;
   assign Timeout_H   = r_timeout;
   assign TimeoutChan = r_tchan;

endmodule

// File: tb/tb_dtack_wait_state_generator.sv
// Directed bench for dtack_wait_state_generator with TIMEOUT=20.
// Vector table for short cycles, hand sequences for long waits and timeouts.
module tb_dtack_wait_state_generator;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        as_l;
   logic [3:0]  sel;
   logic [3:0]  ue;
   logic [15:0] ws;
   logic [3:0]  ext;
   logic        clr;
   logic        dtack_l;
   logic        berr_l;
   logic        to_h;
   logic [3:0]  to_ch;

   int nchk = 0;
   int nerr = 0;
   logic       et;
   logic [3:0] ec;

   typedef struct {
      logic        rst;
      logic        as;
      logic [3:0]  sel;
      logic [3:0]  ue;
      logic [15:0] ws;
      logic [3:0]  ext;
      logic        clr;
      logic        d;
      logic        b;
      logic        t;
      logic [3:0]  c;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   dtack_wait_state_generator #(
      .NUM_CH(4),
      .WS_W(4),
      .TO_W(10),
      .TIMEOUT(20)
   ) dut (
      .Clock(clk),
      .Reset_L(rst_l),
      .AS_L(as_l),
      .Select_H(sel),
      .UseExt_H(ue),
      .WaitStates(ws),
      .ExtDtack_L(ext),
      .ClearTimeout_H(clr),
      .DtackOut_L(dtack_l),
      .BErr_L(berr_l),
      .Timeout_H(to_h),
      .TimeoutChan(to_ch)
   );

   function automatic void add(
      input logic r, input logic a, input logic [3:0] s,
      input logic [3:0] u, input logic [15:0] w, input logic [3:0] e,
      input logic cl, input logic d, input logic b,
      input logic t, input logic [3:0] c);
      vec_t v;
      v.rst = r; v.as = a; v.sel = s; v.ue = u; v.ws = w;
      v.ext = e; v.clr = cl; v.d = d; v.b = b; v.t = t; v.c = c;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic d, input logic b,
                      input logic t, input logic [3:0] c);
      @(posedge clk);
      #1;
      nchk++;
      if (dtack_l !== d || berr_l !== b || to_h !== t || to_ch !== c) begin
         nerr++;
         $display("FAIL %s: got dtack=%b berr=%b to=%b ch=%0d, want dtack=%b berr=%b to=%b ch=%0d",
                  nm, dtack_l, berr_l, to_h, to_ch, d, b, t, c);
      end
   endtask

   task automatic to_cycle(input logic [3:0] s, input logic [3:0] ch,
                           input logic ext_low, input logic clr_end);
      logic [3:0] one;
      one = 4'b0001 << ch;
      sel = s; ue = s; ws = '0; ext = 4'hF; clr = 1'b0; as_l = 1'b0;
      for (int m = 0; m < 20; m++) chk("to_wait", 1, 1, et, ec);
      if (ext_low) ext = ~one;
      clr = clr_end;
      if (ext_low) begin
         chk("to_race", 0, 1, et, ec);
      end else begin
         et = 1'b1; ec = ch;
         chk("to_berr", 1, 0, et, ec);
      end
      clr = 1'b0;
      chk("to_hold", !ext_low, ext_low, et, ec);
      as_l = 1'b1; ext = 4'hF;
      chk("to_rel", 1, 1, et, ec);
   endtask

   initial begin
      rst_l = 1'b0; as_l = 1'b1; sel = '0; ue = '0;
      ws = '0; ext = 4'hF; clr = 1'b0;

      // reset and default device
      repeat (3) add(0, 1, 4'h0, 4'h0, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      add(1, 1, 4'h0, 4'h0, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 16'h0, 4'hF, 0, 0, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 16'h0, 4'hF, 0, 0, 1, 0, 0);
      add(1, 1, 4'h0, 4'h0, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      add(1, 1, 4'h0, 4'h0, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      // channel 2, five wait states
      add(1, 0, 4'h4, 4'h0, 16'h0500, 4'hF, 0, 1, 1, 0, 0);
      repeat (4) add(1, 0, 4'h4, 4'h0, 16'h0500, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h4, 4'h0, 16'h0500, 4'hF, 0, 0, 1, 0, 0);
      add(1, 0, 4'h4, 4'h0, 16'h0500, 4'hF, 0, 0, 1, 0, 0);
      add(1, 1, 4'h4, 4'h0, 16'h0500, 4'hF, 0, 1, 1, 0, 0);
      // channel 2, zero wait states
      add(1, 0, 4'h4, 4'h0, 16'h0000, 4'hF, 0, 0, 1, 0, 0);
      add(1, 1, 4'h4, 4'h0, 16'h0000, 4'hF, 0, 1, 1, 0, 0);
      // channel 1 external, DTACK at k+7
      repeat (7) add(1, 0, 4'h2, 4'h2, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h2, 4'h2, 16'h0, 4'hD, 0, 0, 1, 0, 0);
      add(1, 1, 4'h2, 4'h2, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      // external DTACK together with AS_L high: abort wins
      repeat (2) add(1, 0, 4'h2, 4'h2, 16'h0, 4'hF, 0, 1, 1, 0, 0);
      add(1, 1, 4'h2, 4'h2, 16'h0, 4'hD, 0, 1, 1, 0, 0);
      add(1, 1, 4'h2, 4'h2, 16'h0, 4'hD, 0, 1, 1, 0, 0);
      // priority 0110 -> ch1 (2 ws); select dropped after k is ignored
      add(1, 0, 4'h6, 4'h0, 16'h0520, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 16'h0520, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 16'h0520, 4'hF, 0, 0, 1, 0, 0);
      add(1, 1, 4'h0, 4'h0, 16'h0520, 4'hF, 0, 1, 1, 0, 0);
      // abort of an 8 wait-state cycle at k+3, then a fresh cycle
      repeat (3) add(1, 0, 4'h2, 4'h0, 16'h0080, 4'hF, 0, 1, 1, 0, 0);
      add(1, 1, 4'h2, 4'h0, 16'h0080, 4'hF, 0, 1, 1, 0, 0);
      add(1, 1, 4'h2, 4'h0, 16'h0080, 4'hF, 0, 1, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 16'h0080, 4'hF, 0, 0, 1, 0, 0);
      add(1, 1, 4'h0, 4'h0, 16'h0080, 4'hF, 0, 1, 1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_l = tbl[i].rst; as_l = tbl[i].as; sel = tbl[i].sel;
         ue = tbl[i].ue; ws = tbl[i].ws; ext = tbl[i].ext; clr = tbl[i].clr;
         chk($sformatf("vec%0d", i), tbl[i].d, tbl[i].b, tbl[i].t, tbl[i].c);
      end

      et = 1'b0; ec = 4'd0;

      // fifteen wait states on channel 2
      sel = 4'h4; ue = 4'h0; ws = 16'h0F00; as_l = 1'b0;
      for (int m = 0; m < 15; m++) chk("ws15_wait", 1, 1, et, ec);
      chk("ws15_ack", 0, 1, et, ec);
      as_l = 1'b1;
      chk("ws15_rel", 1, 1, et, ec);

      // channel 3 timeout
      to_cycle(4'h8, 4'd3, 1'b0, 1'b0);
      clr = 1'b1; et = 1'b0;
      chk("clear", 1, 1, et, ec);
      clr = 1'b0;
      // DTACK on the timeout edge: ACK, no flag
      to_cycle(4'h8, 4'd3, 1'b1, 1'b0);
      // channel 0 wins 1001; clear on the setting edge loses
      to_cycle(4'h9, 4'd0, 1'b0, 1'b1);

      // reset mid-WAIT at k+4
      sel = 4'h4; ue = 4'h0; ws = 16'h0800; as_l = 1'b0;
      for (int m = 0; m < 4; m++) chk("rst_wait", 1, 1, et, ec);
      rst_l = 1'b0; et = 1'b0; ec = 4'd0;
      chk("rst_mid", 1, 1, et, ec);
      rst_l = 1'b1; as_l = 1'b1;
      chk("rst_idle", 1, 1, et, ec);
      sel = 4'h0; as_l = 1'b0;
      chk("rst_after", 0, 1, et, ec);
      as_l = 1'b1;
      chk("rst_rel", 1, 1, et, ec);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
